ccx_ic_arbiter: RTL and testbench
=================================

// Module: ccx_ic_arbiter
// PURPOSE
//  Two-master arbiter in front of ccx_ic_router. Merges CPU instruction (imem) and data (dmem)
//  core_mem_bus requests onto one core_mem_bus that feeds the router. Steers each one-cycle
//  delayed response back to the master whose request was granted.
//  Fair round-robin arbitration. Held requests are locked until they are granted.
// PARAMETERS
//  AW  39  address width (matches router)
//  DW  64  data width; strobe width is DW/8
// PORTS
//  g_clk     in   1        clock
//  g_resetn  in   1        synchronous, active-low reset
//  if_imem   core_mem_bus.REQ  -  instruction master (AW/DW above); arbiter acts as responder
//  if_dmem   core_mem_bus.REQ  -  data master; arbiter acts as responder
//  if_out    core_mem_bus.RSP  -  single stream to ccx_ic_router.if_core; arbiter acts as requestor
//  Bus signals per port: req, gnt, wen, addr[AW], strb[DW/8], wdata[DW], rdata[DW], err.
// BEHAVIOUR
//  Protocol
//   - A transfer occurs on a cycle with req && gnt.
//   - rdata/err for that transfer are valid exactly one cycle later (router latency).
//   - A master holds req/addr/wen/strb/wdata stable until gnt.
//  Selection (combinational, from state)
//   - If lock_vld: sel = lock_src.
//   - Else if exactly one master has req: sel = that master.
//   - Else if both have req: sel = the master NOT in last_src (round robin).
//   - Else: sel = last_src (value don't-care; if_out.req = 0).
//  Request path
//   - if_out.{addr,wen,strb,wdata} = selected master's fields; if_out.req = sel.req.
//   - sel.gnt = if_out.gnt; non-selected master gnt = 0.
//  Lock FSM (states UNLOCKED / LOCKED_I / LOCKED_D)
//   - UNLOCKED -> LOCKED_x when if_out.req && !if_out.gnt with sel = x.
//   - LOCKED_x -> UNLOCKED when if_out.gnt, or when master x drops req.
//     Dropping req is a protocol violation; an assertion must fire.
//   - Effect: address presented to the router never switches masters mid-stall.
//  last_src
//   - Updated to sel on every if_out.req && if_out.gnt.
//  Response steering
//   - rsp_i / rsp_d flops are set for one cycle after a grant to imem / dmem respectively.
//   - When rsp_x = 1: master x rdata = if_out.rdata and err = if_out.err.
//     The other master sees rdata = 0 and err = 0.
//   - When neither is set, both masters see rdata = 0 and err = 0.
//   - rsp_i and rsp_d are one-hot or zero, never both.
//  Back-to-back operation
//   - A new grant and a returning response in the same cycle are legal.
//   - Full throughput is 1 transfer/cycle across both masters.
//  Reset (g_resetn = 0, sampled at posedge)
//   - Values: lock = UNLOCKED, last_src = CCX_SRC_IMEM (dmem wins the first tie), rsp_i = rsp_d = 0.
//   - All gnt and if_out.req are combinationally 0 while no master requests.
//   - Reset mid-transfer drops any pending response: no rdata/err is forwarded the cycle after reset.
//  Error path
//   - Unmapped addresses are handled by the router (gnt = 1, err = 1 next cycle).
//   - The arbiter forwards that err unchanged to the owning master.
// STRUCTURE
//  - ccx_pkg gets: typedef enum logic {CCX_SRC_IMEM, CCX_SRC_DMEM} ccx_src_t.
//  - ccx_pkg also gets: typedef enum logic[1:0] {CCX_ARB_UNLOCKED, CCX_ARB_LOCKED_I, CCX_ARB_LOCKED_D}.
//  - No sub-module: the datapath is a 2:1 mux plus three small state registers.
//  - Protocol assertions go in an `ifdef CCX_ASSERT block.
// TESTING
//  1. imem req addr 0x100, gnt = 1
//     -> if_out.addr = 0x100; next cycle rdata 0xDEAD goes to imem only; dmem rdata = 0.
//  2. Both req after reset, gnt = 1 each cycle
//     -> grant order dmem, imem, dmem, imem; responses arrive 1 cycle later to the matching master.
//  3. dmem req 0x10000, gnt = 0 for 3 cycles, imem raises req in cycle 1
//     -> if_out.addr stays 0x10000 until gnt; imem is granted the cycle after.
//  4. dmem write 0x10000000, strb 0xFF, wdata 0x1122334455667788
//     -> if_out mirrors all fields; if_out.wen = 1; err from router returns to dmem.
//  5. imem req unmapped 0x80000000
//     -> gnt the same cycle; imem err = 1 next cycle; dmem err = 0.
//  6. Grant imem, assert reset the next cycle
//     -> no response forwarded; lock UNLOCKED; next tie grants dmem.

Source files
------------

// File: rtl/ccx_pkg.sv
// Shared types for the ccx interconnect: master identifiers, arbiter lock states and bus widths.
package ccx_pkg;

  localparam int CCX_AW = 39;
  localparam int CCX_DW = 64;

  typedef enum logic {
    CCX_SRC_IMEM,
    CCX_SRC_DMEM
  } ccx_src_t;

  typedef enum logic [1:0] {
    CCX_ARB_UNLOCKED,
    CCX_ARB_LOCKED_I,
    CCX_ARB_LOCKED_D
  } ccx_arb_state_t;

  function automatic ccx_src_t ccx_other_src(input ccx_src_t src);
    return (src == CCX_SRC_IMEM) ? CCX_SRC_DMEM : CCX_SRC_IMEM;
  endfunction

endpackage

// File: rtl/core_mem_bus.sv
// Core memory bus: req/gnt handshake with read data and error returned one cycle after the transfer.
interface core_mem_bus #(
  parameter int AW = 39,
  parameter int DW = 64
) ();

  logic              req;
  logic              gnt;
  logic              wen;
  logic [AW-1:0]     addr;
  logic [DW/8-1:0]   strb;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     rdata;
  logic              err;

  // REQ is the view of whoever receives requests; RSP is the view of whoever issues them.
  modport REQ (input req, wen, addr, strb, wdata, output gnt, rdata, err);
  modport RSP (output req, wen, addr, strb, wdata, input gnt, rdata, err);

endinterface

// File: rtl/ccx_ic_arbiter.sv
// Round-robin arbiter merging the imem and dmem masters onto the single router port,
// with stall locking and one-cycle-delayed response steering.
module ccx_ic_arbiter
  import ccx_pkg::*;
#(
  parameter int AW = CCX_AW,
  parameter int DW = CCX_DW
) (
  input  logic     g_clk,
  input  logic     g_resetn,
  core_mem_bus.REQ if_imem,
  core_mem_bus.REQ if_dmem,
  core_mem_bus.RSP if_out
);

  ccx_arb_state_t  lock_q;
  ccx_arb_state_t  lock_d;
  ccx_src_t        last_src_q;
  ccx_src_t        sel;
  logic            rsp_i_q;
  logic            rsp_d_q;
  logic            xfer;

  logic            sel_req;
  logic            sel_wen;
  logic [AW-1:0]   sel_addr;
  logic [DW/8-1:0] sel_strb;
  logic [DW-1:0]   sel_wdata;

  // A stalled master keeps ownership so the router never sees the address switch mid-stall.
  always_comb begin
    sel = last_src_q;
    if (lock_q == CCX_ARB_LOCKED_I) begin
      sel = CCX_SRC_IMEM;
    end else if (lock_q == CCX_ARB_LOCKED_D) begin
      sel = CCX_SRC_DMEM;
    end else if (if_imem.req && if_dmem.req) begin
      sel = ccx_other_src(last_src_q);
    end else if (if_imem.req) begin
      sel = CCX_SRC_IMEM;
    end else if (if_dmem.req) begin
      sel = CCX_SRC_DMEM;
    end
  end

  always_comb begin
    if (sel == CCX_SRC_IMEM) begin
      sel_req   = if_imem.req;
      sel_wen   = if_imem.wen;
      sel_addr  = if_imem.addr;
      sel_strb  = if_imem.strb;
      sel_wdata = if_imem.wdata;
    end else begin
      sel_req   = if_dmem.req;
      sel_wen   = if_dmem.wen;
      sel_addr  = if_dmem.addr;
      sel_strb  = if_dmem.strb;
      sel_wdata = if_dmem.wdata;
    end
  end

  assign if_out.req   = sel_req;
  assign if_out.wen   = sel_wen;
  assign if_out.addr  = sel_addr;
  assign if_out.strb  = sel_strb;
  assign if_out.wdata = sel_wdata;

  // Grants are qualified by the selected request so an always-ready router never leaks a gnt.
  assign xfer        = sel_req && if_out.gnt;
  assign if_imem.gnt = xfer && (sel == CCX_SRC_IMEM);
  assign if_dmem.gnt = xfer && (sel == CCX_SRC_DMEM);

  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      CCX_ARB_UNLOCKED: begin
        if (sel_req && !if_out.gnt) begin
          lock_d = (sel == CCX_SRC_IMEM) ? CCX_ARB_LOCKED_I : CCX_ARB_LOCKED_D;
        end
      end
      CCX_ARB_LOCKED_I: begin
        if (if_out.gnt || !if_imem.req) begin
          lock_d = CCX_ARB_UNLOCKED;
        end
      end
      CCX_ARB_LOCKED_D: begin
        if (if_out.gnt || !if_dmem.req) begin
          lock_d = CCX_ARB_UNLOCKED;
        end
      end
      default: lock_d = CCX_ARB_UNLOCKED;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lock_q     <= CCX_ARB_UNLOCKED;
      last_src_q <= CCX_SRC_IMEM;
      rsp_i_q    <= 1'b0;
      rsp_d_q    <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      rsp_i_q <= xfer && (sel == CCX_SRC_IMEM);
      rsp_d_q <= xfer && (sel == CCX_SRC_DMEM);
      if (xfer) begin
        last_src_q <= sel;
      end
    end
  end

  // Response data follows the router one cycle behind the grant; the idle master sees zeros.
  assign if_imem.rdata = rsp_i_q ? if_out.rdata : '0;
  assign if_imem.err   = rsp_i_q ? if_out.err   : 1'b0;
  assign if_dmem.rdata = rsp_d_q ? if_out.rdata : '0;
  assign if_dmem.err   = rsp_d_q ? if_out.err   : 1'b0;

`ifdef CCX_ASSERT
  a_imem_held: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (lock_q == CCX_ARB_LOCKED_I) |-> if_imem.req);
  a_dmem_held: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (lock_q == CCX_ARB_LOCKED_D) |-> if_dmem.req);
  a_rsp_onehot: assert property (@(posedge g_clk) disable iff (!g_resetn)
    !(rsp_i_q && rsp_d_q));
`endif

endmodule

// File: tb/tb_ccx_ic_arbiter.sv
// Self-checking bench for ccx_ic_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of round-robin arbitration, stall ownership and delayed responses.
module tb_ccx_ic_arbiter;

  logic g_clk = 1'b0;
  logic g_resetn;

  always #5 g_clk = ~g_clk;

  core_mem_bus #(.AW(39), .DW(64)) imem_bus ();
  core_mem_bus #(.AW(39), .DW(64)) dmem_bus ();
  core_mem_bus #(.AW(39), .DW(64)) out_bus ();

  ccx_ic_arbiter #(.AW(39), .DW(64)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .if_imem  (imem_bus),
    .if_dmem  (dmem_bus),
    .if_out   (out_bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: 0 = imem, 1 = dmem, -1 = nobody.
  int          m_last = 0;
  int          m_lock = -1;
  int          exp_who = -1;
  logic [63:0] exp_data = '0;
  logic        exp_err = 1'b0;
  logic [63:0] rtr_rdata = '0;

  // Router stand-in: data and err for a transfer appear next cycle, junk otherwise.
  always @(posedge g_clk) begin
    if (out_bus.req && out_bus.gnt) begin
      out_bus.rdata <= rtr_rdata;
      out_bus.err   <= out_bus.addr[31];
    end else begin
      out_bus.rdata <= {$urandom(), $urandom()};
      out_bus.err   <= 1'($urandom_range(0, 1));
    end
  end

  function automatic int model_pick(input logic ireq, input logic dreq);
    if (m_lock >= 0) return m_lock;
    if (ireq && dreq) return 1 - m_last;
    if (ireq) return 0;
    if (dreq) return 1;
    return -1;
  endfunction

  task automatic drive_imem(input logic req, input logic [38:0] addr, input logic wen,
                            input logic [7:0] strb, input logic [63:0] wdata);
    imem_bus.req = req; imem_bus.addr = addr; imem_bus.wen = wen;
    imem_bus.strb = strb; imem_bus.wdata = wdata;
  endtask

  task automatic drive_dmem(input logic req, input logic [38:0] addr, input logic wen,
                            input logic [7:0] strb, input logic [63:0] wdata);
    dmem_bus.req = req; dmem_bus.addr = addr; dmem_bus.wen = wen;
    dmem_bus.strb = strb; dmem_bus.wdata = wdata;
  endtask

  // Advance one clock and update the model with what the transfer rules say happened.
  task automatic tick(input logic [63:0] rd);
    int p; logic preq; logic pg; logic [38:0] a;
    p    = model_pick(imem_bus.req, dmem_bus.req);
    preq = (p == 0) ? imem_bus.req : (p == 1) ? dmem_bus.req : 1'b0;
    a    = (p == 0) ? imem_bus.addr : dmem_bus.addr;
    pg   = out_bus.gnt;
    rtr_rdata = rd;
    @(posedge g_clk);
    if (!g_resetn) begin
      m_last = 0; m_lock = -1; exp_who = -1;
    end else if (preq && pg) begin
      exp_who = p; exp_data = rd; exp_err = a[31]; m_last = p; m_lock = -1;
    end else begin
      exp_who = -1; m_lock = preq ? p : -1;
    end
    @(negedge g_clk);
  endtask

  task automatic apply_reset();
    g_resetn = 1'b0;
    drive_imem(0, '0, 0, '0, '0);
    drive_dmem(0, '0, 0, '0, '0);
    tick('0);
    tick('0);
    g_resetn = 1'b1;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    out_bus.gnt = 1'b1;
    drive_imem(0, '0, 0, '0, '0);
    drive_dmem(0, '0, 0, '0, '0);
    tick('0);
    tick('0);
    #1;
    checks++;
    if (out_bus.req !== 1'b0) begin errors++; $display("FAIL reset_out_req got %b exp 0", out_bus.req); end
    checks++;
    if ({imem_bus.gnt, dmem_bus.gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {imem_bus.gnt, dmem_bus.gnt}); end
    checks++;
    if (imem_bus.rdata !== 64'h0 || dmem_bus.rdata !== 64'h0 || imem_bus.err !== 1'b0 || dmem_bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp got i=%h/%b d=%h/%b exp zero", imem_bus.rdata, imem_bus.err, dmem_bus.rdata, dmem_bus.err);
    end
    g_resetn = 1'b1;
    tick('0);
    #1;
    checks++;
    if ({out_bus.req, imem_bus.gnt, dmem_bus.gnt} !== 3'b000) begin errors++; $display("FAIL idle_gnt got %b exp 000", {out_bus.req, imem_bus.gnt, dmem_bus.gnt}); end
  endtask

  task automatic test_single_imem();
    drive_imem(1, 39'h100, 0, '0, '0);
    out_bus.gnt = 1'b1;
    #1;
    checks++;
    if (out_bus.addr !== 39'h100 || imem_bus.gnt !== 1'b1) begin
      errors++; $display("FAIL imem_req got addr=%h gnt=%b exp addr=100 gnt=1", out_bus.addr, imem_bus.gnt);
    end
    tick(64'hDEAD);
    drive_imem(0, '0, 0, '0, '0);
    #1;
    checks++;
    if (imem_bus.rdata !== 64'hDEAD || dmem_bus.rdata !== 64'h0) begin
      errors++; $display("FAIL imem_rsp got i=%h d=%h exp i=dead d=0", imem_bus.rdata, dmem_bus.rdata);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    drive_imem(1, 39'h200, 0, '0, '0);
    drive_dmem(1, 39'h300, 0, '0, '0);
    out_bus.gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic want_d;
      want_d = (k % 2 == 0);
      #1;
      checks++;
      if (dmem_bus.gnt !== want_d || imem_bus.gnt !== !want_d || out_bus.addr !== (want_d ? 39'h300 : 39'h200)) begin
        errors++; $display("FAIL rr_order[%0d] got i=%b d=%b addr=%h exp d=%b", k, imem_bus.gnt, dmem_bus.gnt, out_bus.addr, want_d);
      end
      tick(64'h1000 + 64'(k));
      checks++;
      if (want_d ? (dmem_bus.rdata !== 64'h1000 + 64'(k) || imem_bus.rdata !== 64'h0)
                 : (imem_bus.rdata !== 64'h1000 + 64'(k) || dmem_bus.rdata !== 64'h0)) begin
        errors++; $display("FAIL rr_rsp[%0d] got i=%h d=%h exp data %h", k, imem_bus.rdata, dmem_bus.rdata, 64'h1000 + 64'(k));
      end
    end
    drive_imem(0, '0, 0, '0, '0);
    drive_dmem(0, '0, 0, '0, '0);
  endtask

  task automatic test_stall_lock();
    // A dmem grant first makes imem the round-robin favourite, so only the lock keeps dmem selected.
    drive_dmem(1, 39'h50, 0, '0, '0);
    out_bus.gnt = 1'b1;
    tick('0);
    drive_dmem(1, 39'h10000, 0, '0, '0);
    out_bus.gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drive_imem(1, 39'h400, 0, '0, '0);
      #1;
      checks++;
      if (out_bus.addr !== 39'h10000 || imem_bus.gnt !== 1'b0 || dmem_bus.gnt !== 1'b0) begin
        errors++; $display("FAIL stall[%0d] got addr=%h i=%b d=%b exp addr=10000 no gnt", c, out_bus.addr, imem_bus.gnt, dmem_bus.gnt);
      end
      tick('0);
    end
    out_bus.gnt = 1'b1;
    #1;
    checks++;
    if (out_bus.addr !== 39'h10000 || dmem_bus.gnt !== 1'b1 || imem_bus.gnt !== 1'b0) begin
      errors++; $display("FAIL stall_release got addr=%h i=%b d=%b exp dmem", out_bus.addr, imem_bus.gnt, dmem_bus.gnt);
    end
    tick(64'h77);
    drive_dmem(0, '0, 0, '0, '0);
    #1;
    checks++;
    if (imem_bus.gnt !== 1'b1 || out_bus.addr !== 39'h400 || dmem_bus.rdata !== 64'h77) begin
      errors++; $display("FAIL stall_next got i=%b addr=%h drd=%h exp i=1 addr=400 drd=77", imem_bus.gnt, out_bus.addr, dmem_bus.rdata);
    end
    tick('0);
    drive_imem(0, '0, 0, '0, '0);
  endtask

  task automatic test_write();
    drive_dmem(1, 39'h10000000, 1, 8'hFF, 64'h1122334455667788);
    out_bus.gnt = 1'b1;
    #1;
    checks++;
    if (out_bus.addr !== 39'h10000000 || out_bus.wen !== 1'b1 || out_bus.strb !== 8'hFF ||
        out_bus.wdata !== 64'h1122334455667788 || dmem_bus.gnt !== 1'b1) begin
      errors++; $display("FAIL write_fields got addr=%h wen=%b strb=%h wdata=%h gnt=%b", out_bus.addr, out_bus.wen, out_bus.strb, out_bus.wdata, dmem_bus.gnt);
    end
    tick(64'h5A5A);
    drive_dmem(0, '0, 0, '0, '0);
    #1;
    checks++;
    if (dmem_bus.err !== 1'b0 || dmem_bus.rdata !== 64'h5A5A || imem_bus.rdata !== 64'h0) begin
      errors++; $display("FAIL write_rsp got derr=%b drd=%h ird=%h exp 0/5a5a/0", dmem_bus.err, dmem_bus.rdata, imem_bus.rdata);
    end
  endtask

  task automatic test_unmapped();
    drive_imem(1, 39'h80000000, 0, '0, '0);
    out_bus.gnt = 1'b1;
    #1;
    checks++;
    if (imem_bus.gnt !== 1'b1) begin errors++; $display("FAIL unmapped_gnt got %b exp 1", imem_bus.gnt); end
    tick('0);
    drive_imem(0, '0, 0, '0, '0);
    #1;
    checks++;
    if (imem_bus.err !== 1'b1 || dmem_bus.err !== 1'b0) begin
      errors++; $display("FAIL unmapped_err got i=%b d=%b exp i=1 d=0", imem_bus.err, dmem_bus.err);
    end
  endtask

  task automatic test_reset_mid();
    drive_imem(1, 39'h140, 0, '0, '0);
    out_bus.gnt = 1'b1;
    tick(64'hBEEF);
    g_resetn = 1'b0;
    drive_imem(0, '0, 0, '0, '0);
    tick('0);
    g_resetn = 1'b1;
    #1;
    checks++;
    if (imem_bus.rdata !== 64'h0 || imem_bus.err !== 1'b0 || dmem_bus.rdata !== 64'h0 || dmem_bus.err !== 1'b0) begin
      errors++; $display("FAIL reset_drop got i=%h/%b d=%h/%b exp zero", imem_bus.rdata, imem_bus.err, dmem_bus.rdata, dmem_bus.err);
    end
    // Grant dmem then stall imem: both the lock and the round-robin history now point at imem.
    drive_dmem(1, 39'h180, 0, '0, '0);
    tick('0);
    drive_dmem(0, '0, 0, '0, '0);
    drive_imem(1, 39'h1C0, 0, '0, '0);
    out_bus.gnt = 1'b0;
    tick('0);
    g_resetn = 1'b0;
    drive_imem(0, '0, 0, '0, '0);
    tick('0);
    g_resetn = 1'b1;
    drive_imem(1, 39'h1C0, 0, '0, '0);
    drive_dmem(1, 39'h200, 0, '0, '0);
    out_bus.gnt = 1'b1;
    #1;
    checks++;
    if (dmem_bus.gnt !== 1'b1 || imem_bus.gnt !== 1'b0 || out_bus.addr !== 39'h200) begin
      errors++; $display("FAIL reset_tie got i=%b d=%b addr=%h exp dmem", imem_bus.gnt, dmem_bus.gnt, out_bus.addr);
    end
    tick('0);
    drive_imem(0, '0, 0, '0, '0);
    drive_dmem(0, '0, 0, '0, '0);
    tick('0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int p; logic ereq; logic [38:0] eaddr; logic [63:0] rd;
      if (!imem_bus.req && $urandom_range(0, 2) != 0)
        drive_imem(1, {7'($urandom()), $urandom()}, 1'($urandom()), 8'($urandom()), {$urandom(), $urandom()});
      if (!dmem_bus.req && $urandom_range(0, 2) != 0)
        drive_dmem(1, {7'($urandom()), $urandom()}, 1'($urandom()), 8'($urandom()), {$urandom(), $urandom()});
      out_bus.gnt = ($urandom_range(0, 3) != 0);
      #1;
      p     = model_pick(imem_bus.req, dmem_bus.req);
      ereq  = (p == 0) ? imem_bus.req : (p == 1) ? dmem_bus.req : 1'b0;
      eaddr = (p == 0) ? imem_bus.addr : dmem_bus.addr;
      checks++;
      if (out_bus.req !== ereq || (ereq && out_bus.addr !== eaddr)) begin
        errors++; $display("FAIL rand_sel[%0d] got req=%b addr=%h exp req=%b addr=%h", c, out_bus.req, out_bus.addr, ereq, eaddr);
      end
      checks++;
      if (imem_bus.gnt !== (ereq && out_bus.gnt && p == 0) || dmem_bus.gnt !== (ereq && out_bus.gnt && p == 1)) begin
        errors++; $display("FAIL rand_gnt[%0d] got i=%b d=%b exp owner %0d gnt %b", c, imem_bus.gnt, dmem_bus.gnt, p, out_bus.gnt);
      end
      rd = {$urandom(), $urandom()};
      tick(rd);
      checks++;
      if (imem_bus.rdata !== ((exp_who == 0) ? exp_data : 64'h0) || imem_bus.err !== ((exp_who == 0) && exp_err) ||
          dmem_bus.rdata !== ((exp_who == 1) ? exp_data : 64'h0) || dmem_bus.err !== ((exp_who == 1) && exp_err)) begin
        errors++; $display("FAIL rand_rsp[%0d] got i=%h/%b d=%h/%b exp owner %0d data %h err %b", c,
                           imem_bus.rdata, imem_bus.err, dmem_bus.rdata, dmem_bus.err, exp_who, exp_data, exp_err);
      end
      if (exp_who == 0) imem_bus.req = 1'b0;
      if (exp_who == 1) dmem_bus.req = 1'b0;
    end
  endtask

  initial begin
    g_resetn = 1'b0;
    out_bus.gnt = 1'b0;
    drive_imem(0, '0, 0, '0, '0);
    drive_dmem(0, '0, 0, '0, '0);
    test_reset();
    test_single_imem();
    test_round_robin();
    test_stall_lock();
    test_write();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
